kt_preset: RTL and testbench

Time-entry front end for the kitchen timer. It turns the MIN and SEC push-buttons into an MM:SS preset held in four BCD digit registers. Presses increment immediately, and holding a button auto-repeats. This block writes the preset; the down-counting borrow chain then runs it out. It also supplies the up-counting, carry-out counterpart of the down-counting digit.

---
 rtl/kt_pkg.sv | 16 +
 rtl/dcounter_up.sv | 31 +++
 rtl/kt_repeat_fsm.sv | 97 +++++++++
 rtl/kt_preset.sv | 72 +++++++
 tb/tb_kt_preset.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/kt_pkg.sv
// Shared constants for the kitchen-timer preset front end: button FSM
// state codes, BCD digit limits and tick-counter width.
package kt_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  localparam logic [3:0] SEC_L_MAX = 4'd9;
  localparam logic [3:0] SEC_H_MAX = 4'd5;
  localparam logic [3:0] MIN_MAX   = 4'd9;

  localparam int TICK_CNT_W = 16;

endpackage

// File: rtl/dcounter_up.sv
// One BCD up-counting digit with carry-in/carry-out; the up-counting
// counterpart of the down-counting borrow-chain digit.
module dcounter_up
  import kt_pkg::*;
#(
  parameter logic [3:0] maxcnt = SEC_L_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] q
);

  logic [3:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (cin) begin
      r_q <= (r_q == maxcnt) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q    = r_q;
  assign cout = cin && (r_q == maxcnt);

endmodule

// File: rtl/kt_repeat_fsm.sv
// Press / hold / auto-repeat / lock state machine for one time-entry button.
// Emits a single-cycle increment request on press and on each repeat.
module kt_repeat_fsm
  import kt_pkg::*;
#(
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_en,
  input  logic i_btn,
  input  logic i_both,
  input  logic i_allUp,
  output logic o_inc
);

  localparam logic [TICK_CNT_W-1:0] HOLD_LAST   = TICK_CNT_W'(HOLD_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] REPEAT_LAST = TICK_CNT_W'(REPEAT_TICKS - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_stateNext;
  logic [TICK_CNT_W-1:0] r_cnt;
  logic [TICK_CNT_W-1:0] w_cntNext;
  logic                  r_btnQ;
  logic                  w_inc;

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_inc       = 1'b0;
    if (!i_en) begin
      w_stateNext = ST_IDLE;
      w_cntNext   = '0;
    end else if (i_both) begin
      w_stateNext = ST_LOCK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_btn && !r_btnQ) begin
            w_inc       = 1'b1;
            w_cntNext   = '0;
            w_stateNext = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!i_btn) begin
            w_stateNext = ST_IDLE;
          end else if (i_tick) begin
            if (r_cnt == HOLD_LAST) begin
              w_inc       = 1'b1;
              w_cntNext   = '0;
              w_stateNext = ST_REPEAT;
            end else begin
              w_cntNext = r_cnt + TICK_CNT_W'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (!i_btn) begin
            w_stateNext = ST_IDLE;
          end else if (i_tick) begin
            if (r_cnt == REPEAT_LAST) begin
              w_inc     = 1'b1;
              w_cntNext = '0;
            end else begin
              w_cntNext = r_cnt + TICK_CNT_W'(1);
            end
          end
        end
        default: begin
          if (i_allUp) begin
            w_stateNext = ST_IDLE;
          end
        end
      endcase
    end
  end

  // The edge detector resets to "pressed" so a button held through reset
  // must be released and pressed again before it counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_btnQ  <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_btnQ  <= i_btn;
    end
  end

  assign o_inc = w_inc;

endmodule

// File: rtl/kt_preset.sv
// MM:SS preset entry: MIN/SEC buttons drive two repeat FSMs that step
// cascaded BCD digits; pressing both buttons clears the preset.
module kt_preset
  import kt_pkg::*;
#(
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       en,
  input  logic       clr,
  input  logic       btn_min,
  input  logic       btn_sec,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       zero
);

  logic w_both;
  logic w_allUp;
  logic w_digClr;
  logic w_incMin;
  logic w_incSec;
  logic w_secCarry;
  logic w_minCarry;
  logic w_unusedSecWrap;
  logic w_unusedMinWrap;
  logic r_zero;

  assign w_both   = en && btn_min && btn_sec;
  assign w_allUp  = !btn_min && !btn_sec;
  assign w_digClr = clr || w_both;

  kt_repeat_fsm #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_minFsm (
    .clk(clk), .reset(reset), .i_tick(tick), .i_en(en), .i_btn(btn_min),
    .i_both(w_both), .i_allUp(w_allUp), .o_inc(w_incMin)
  );

  kt_repeat_fsm #(.HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_secFsm (
    .clk(clk), .reset(reset), .i_tick(tick), .i_en(en), .i_btn(btn_sec),
    .i_both(w_both), .i_allUp(w_allUp), .o_inc(w_incSec)
  );

  // Each field wraps on its own: the tens carry-out goes nowhere.
  dcounter_up #(.maxcnt(SEC_L_MAX)) u_secL (
    .clk(clk), .reset(reset), .clr(w_digClr), .cin(w_incSec), .cout(w_secCarry), .q(sec_l)
  );
  dcounter_up #(.maxcnt(SEC_H_MAX)) u_secH (
    .clk(clk), .reset(reset), .clr(w_digClr), .cin(w_secCarry), .cout(w_unusedSecWrap), .q(sec_h)
  );
  dcounter_up #(.maxcnt(MIN_MAX)) u_minL (
    .clk(clk), .reset(reset), .clr(w_digClr), .cin(w_incMin), .cout(w_minCarry), .q(min_l)
  );
  dcounter_up #(.maxcnt(MIN_MAX)) u_minH (
    .clk(clk), .reset(reset), .clr(w_digClr), .cin(w_minCarry), .cout(w_unusedMinWrap), .q(min_h)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= ({min_h, min_l, sec_h, sec_l} == 16'd0);
    end
  end

  assign zero = r_zero;

endmodule

// File: tb/tb_kt_preset.sv
// Scoreboard bench for kt_preset: stimulus pushes the expected display
// after every modelled change, a monitor pops on every observed change.
module tb_kt_preset;

  localparam int HOLD = 3;
  localparam int REP  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       en;
  logic       clr;
  logic       btnMin;
  logic       btnSec;
  logic [3:0] minH, minL, secH, secL;
  logic       zero;

  typedef struct {
    string       name;
    logic [16:0] val;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   modelMm     = 0;
  int   modelSs     = 0;
  logic modelZero   = 1'b1;
  logic [1:0] tickPh = 2'd0;

  kt_preset #(.HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)) dut (
    .clk(clk), .reset(reset), .tick(tick), .en(en), .clr(clr),
    .btn_min(btnMin), .btn_sec(btnSec),
    .min_h(minH), .min_l(minL), .sec_h(secH), .sec_l(secL), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tickPh = tickPh + 2'd1;
      tick   = (tickPh == 2'd0);
    end
  end

  function automatic logic [16:0] packDisp(int mm, int ss, logic z);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), z};
  endfunction

  function automatic string fmt(logic [16:0] v);
    return $sformatf("%0d%0d:%0d%0d zero=%0b", v[16:13], v[12:9], v[8:5], v[4:1], v[0]);
  endfunction

  task automatic pushExp(string name, int mm, int ss, logic z);
    exp_t e;
    e.name = name;
    e.val  = packDisp(mm, ss, z);
    expQ.push_back(e);
  endtask

  // zero lags the digits by one register stage, so a digit change that
  // flips zero shows up as two successive display changes.
  task automatic modelSet(string name, int mm, int ss);
    logic nz;
    if (mm == modelMm && ss == modelSs) return;
    nz = (mm == 0 && ss == 0);
    pushExp(name, mm, ss, modelZero);
    if (nz != modelZero) pushExp({name, "_zero"}, mm, ss, nz);
    modelMm   = mm;
    modelSs   = ss;
    modelZero = nz;
  endtask

  task automatic modelInc(string name, bit isMin);
    if (isMin) modelSet(name, (modelMm + 1) % 100, modelSs);
    else       modelSet(name, modelMm, (modelSs + 1) % 60);
  endtask

  task automatic applyStimulus(bit bMin, bit bSec, bit enVal, bit clrVal);
    @(negedge clk);
    btnMin = bMin;
    btnSec = bSec;
    en     = enVal;
    clr    = clrVal;
  endtask

  task automatic tap(bit isMin, string name);
    applyStimulus(isMin, !isMin, 1'b1, 1'b0);
    modelInc(name, isMin);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic clearPulse(string name);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    modelSet(name, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Presses one button and keeps it held for n ticks after the press edge.
  task automatic holdCount(bit isMin, int n, string name);
    int k;
    applyStimulus(isMin, !isMin, 1'b1, 1'b0);
    modelInc(name, isMin);
    @(posedge clk);
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) begin
        k++;
        if (k == HOLD || (k > HOLD && (k - HOLD) % REP == 0)) modelInc(name, isMin);
      end
    end
  endtask

  task automatic waitTicks(int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic checkOutput(string name);
    int waitCyc;
    waitCyc = 0;
    while (expQ.size() != 0 && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s: %0d expected display changes still pending (next %s), required 0",
               name, expQ.size(), fmt(expQ[0].val));
      expQ.delete();
    end
  endtask

  initial begin
    logic [16:0] prev;
    logic [16:0] obs;
    exp_t        e;
    prev = 17'h1FFFF;
    forever begin
      @(negedge clk);
      obs = {minH, minL, secH, secL, zero};
      if (obs !== prev) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_change: got %s, required %s", fmt(obs), fmt(prev));
        end else begin
          e = expQ.pop_front();
          if (obs !== e.val) begin
            miscompares++;
            $display("[TB] FAIL %s: got %s, required %s", e.name, fmt(obs), fmt(e.val));
          end
        end
        prev = obs;
      end
    end
  end

  initial begin
    #500000;
    miscompares++;
    $display("[TB] FAIL watchdog: still running at %0t, required finish earlier", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    clr    = 1'b0;
    btnMin = 1'b0;
    btnSec = 1'b0;
    pushExp("reset_state", 0, 0, 1'b1);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    checkOutput("reset_state");

    $display("[TB] SEC tap and seconds wrap");
    tap(1'b0, "sec_tap");
    checkOutput("sec_tap");
    for (int i = 0; i < 57; i++) tap(1'b0, "sec_preset");
    tap(1'b0, "sec_59");
    tap(1'b0, "sec_wrap");
    checkOutput("sec_wrap");

    $display("[TB] MIN carry and minutes wrap");
    for (int i = 0; i < 9; i++) tap(1'b1, "min_preset");
    checkOutput("min_09");
    tap(1'b1, "min_carry");
    for (int i = 0; i < 89; i++) tap(1'b1, "min_preset99");
    tap(1'b1, "min_wrap");
    checkOutput("min_wrap");

    $display("[TB] MIN hold auto-repeat");
    holdCount(1'b1, 7, "min_hold");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitTicks(4);
    checkOutput("min_hold_release");

    $display("[TB] staggered both-pressed clear");
    clearPulse("clr_before_lock");
    for (int i = 0; i < 12; i++) tap(1'b1, "lock_preset_min");
    for (int i = 0; i < 34; i++) tap(1'b0, "lock_preset_sec");
    checkOutput("preset_12_34");
    holdCount(1'b0, 2, "lock_sec_press");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    modelSet("both_clear", 0, 0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitTicks(4);
    checkOutput("lock_min_released");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tap(1'b0, "sec_after_lock");
    checkOutput("sec_after_lock");

    $display("[TB] en low and clr");
    clearPulse("clr_before_en");
    for (int i = 0; i < 5; i++) tap(1'b1, "en_preset_min");
    for (int i = 0; i < 30; i++) tap(1'b0, "en_preset_sec");
    checkOutput("preset_05_30");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("en0_both_hold");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    modelSet("clr_en0", 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    waitTicks(5);
    checkOutput("en_return_held");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tap(1'b0, "sec_after_en");
    checkOutput("sec_after_en");

    $display("[TB] reset during auto-repeat");
    holdCount(1'b1, 5, "min_repeat");
    @(negedge clk);
    #2;
    modelMm   = 0;
    modelSs   = 0;
    modelZero = 1'b1;
    pushExp("reset_mid_repeat", 0, 0, 1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    waitTicks(6);
    checkOutput("reset_held_no_inc");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tap(1'b1, "min_after_reset");
    checkOutput("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
